// File: rtl/dm_pkg.sv
// Shared types and constants for the clocked data memory.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned WCNT_W = 4;
    localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/data_memory_sync_if.sv
// Request/response bus between the load/store unit and the data memory.
interface data_memory_sync_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_ram_array.sv
// Byte-lane writable storage array with a registered read port.
module dm_ram_array #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned AW     = 10
) (
    input  logic                clk,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Write enabled byte lanes; read port always tracks addr one cycle later.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DATA_W / 8); i++) begin
            if (we && be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/data_memory_sync.sv
// Clocked data memory: valid/ready request port, byte enables, WAIT_CYC wait
// states and an out-of-range error response. One request in flight at a time.
// Optional: define DM_STATS_EN to add saturating read/write/error counters.
module data_memory_sync
    import dm_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned WAIT_CYC = 0
) (
    input logic               clk,
    input logic               rst,
    data_memory_sync_if.slave bus
`ifdef DM_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_rd,
    output logic [STAT_W-1:0] stat_wr,
    output logic [STAT_W-1:0] stat_err
`endif
);
    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WCNT_W-1:0] WaitLoad =
        (WAIT_CYC > 0) ? WCNT_W'(WAIT_CYC - 1) : '0;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
    endfunction

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   rdata_hold_q;
    logic                err_hold_q;

    logic                ready, hs, commit;
    logic                cur_we;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic [BE_W-1:0]     cur_be;
    logic                ram_we;
    logic [AW-1:0]       ram_addr;
    logic [DATA_W-1:0]   ram_rdata;
    logic [DATA_W-1:0]   resp_data;
    logic                resp_err;

    assign ready = (state_q == IDLE) && !rst;
    assign hs    = bus.req_valid && ready;

    // With WAIT_CYC=0 the commit edge is the handshake edge, so use the live request.
    assign cur_we    = (state_q == IDLE) ? bus.req_we    : we_q;
    assign cur_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
    assign cur_be    = (state_q == IDLE) ? bus.req_be    : be_q;

    assign commit   = !rst && (state_q != RESP) && (state_d == RESP);
    assign ram_we   = commit && cur_we && addr_ok(cur_addr);
    assign ram_addr = addr_ok(cur_addr) ? cur_addr[AW-1:0] : '0;

    dm_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (cur_be),
        .addr  (ram_addr),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    // State and wait counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    if (WAIT_CYC > 0) begin
                        state_d = WAIT;
                        cnt_d   = WaitLoad;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and response hold registers.
    always_ff @(posedge clk) begin
        if (hs) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
        end
        if (rst) begin
            rdata_hold_q <= '0;
            err_hold_q   <= 1'b0;
        end else if (state_q == RESP) begin
            rdata_hold_q <= resp_data;
            err_hold_q   <= resp_err;
        end
    end

    // Outputs: live response in RESP, held values otherwise, zero under reset.
    always_comb begin
        resp_err      = !addr_ok(addr_q);
        resp_data     = (!we_q && !resp_err) ? ram_rdata : '0;
        bus.req_ready = ready;
        bus.rsp_valid = (state_q == RESP) && !rst;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        if (!rst) begin
            bus.rsp_rdata = (state_q == RESP) ? resp_data : rdata_hold_q;
            bus.rsp_err   = (state_q == RESP) ? resp_err : err_hold_q;
        end
    end

`ifdef DM_STATS_EN
    // Saturating completion counters; an error counts only as an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd  <= '0;
            stat_wr  <= '0;
            stat_err <= '0;
        end else if (state_q == RESP) begin
            if (resp_err) begin
                if (stat_err != '1) stat_err <= stat_err + 1'b1;
            end else if (we_q) begin
                if (stat_wr != '1) stat_wr <= stat_wr + 1'b1;
            end else begin
                if (stat_rd != '1) stat_rd <= stat_rd + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_data_memory_sync.sv
// Self-checking bench: two instances (WAIT_CYC=0 and WAIT_CYC=3) sharing one
// clock and reset; directed table, hand sequences and randomized traffic.
module tb_data_memory_sync;
    localparam int unsigned W3 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_memory_sync_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();
    data_memory_sync_if #(.DATA_W(16), .ADDR_W(16)) bus3 ();

    logic        valid_d, sel_d, we_d;
    logic [15:0] addr_d, wdata_d;
    logic [1:0]  be_d;

    assign bus0.req_valid = valid_d && !sel_d;
    assign bus3.req_valid = valid_d && sel_d;
    assign bus0.req_we    = we_d;
    assign bus3.req_we    = we_d;
    assign bus0.req_addr  = addr_d;
    assign bus3.req_addr  = addr_d;
    assign bus0.req_wdata = wdata_d;
    assign bus3.req_wdata = wdata_d;
    assign bus0.req_be    = be_d;
    assign bus3.req_be    = be_d;

`ifdef DM_STATS_EN
    logic [15:0] stat_rd0, stat_wr0, stat_err0, stat_rd3, stat_wr3, stat_err3;
`endif

    data_memory_sync #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYC(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
`ifdef DM_STATS_EN
        ,
        .stat_rd  (stat_rd0),
        .stat_wr  (stat_wr0),
        .stat_err (stat_err0)
`endif
    );

    data_memory_sync #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYC(W3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
`ifdef DM_STATS_EN
        ,
        .stat_rd  (stat_rd3),
        .stat_wr  (stat_wr3),
        .stat_err (stat_err3)
`endif
    );

    logic        cur_ready, cur_valid, cur_err;
    logic [15:0] cur_rdata;
    assign cur_ready = sel_d ? bus3.req_ready : bus0.req_ready;
    assign cur_valid = sel_d ? bus3.rsp_valid : bus0.rsp_valid;
    assign cur_err   = sel_d ? bus3.rsp_err   : bus0.rsp_err;
    assign cur_rdata = sel_d ? bus3.rsp_rdata : bus0.rsp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memory image per instance; index 0 = WAIT_CYC 0, 1 = WAIT_CYC 3.
    logic [15:0] model [2][1024];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected response from the spec rules; updates the image on in-range writes.
    task automatic model_apply(input logic sel, input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [1:0] be,
                               output logic [15:0] er, output logic ee);
        logic [15:0] mask;
        int s;
        s = sel ? 1 : 0;
        mask = {{8{be[1]}}, {8{be[0]}}};
        if (int'(addr) >= 1024) begin
            er = 16'h0;
            ee = 1'b1;
        end else if (we) begin
            model[s][addr] = (model[s][addr] & ~mask) | (wdata & mask);
            er = 16'h0;
            ee = 1'b0;
        end else begin
            er = model[s][addr];
            ee = 1'b0;
        end
    endtask

    // One full transaction, starting and ending at a falling edge.
    task automatic txn(input string tag, input logic sel, input logic we,
                       input logic [15:0] addr, input logic [15:0] wdata, input logic [1:0] be,
                       input logic [15:0] exp_rdata, input logic exp_err);
        int guard;
        int lat;
        int exp_lat;
        exp_lat = sel ? 1 + int'(W3) : 1;
        sel_d = sel; we_d = we; addr_d = addr; wdata_d = wdata; be_d = be; valid_d = 1'b1;
        #1;
        guard = 0;
        while (!cur_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, 32'(cur_ready), 32'd1);
        @(negedge clk);
        valid_d = 1'b0;
        lat = 1;
        while (!cur_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, 32'(cur_rdata), 32'(exp_rdata));
        check({tag, "_err"}, 32'(cur_err), 32'(exp_err));
        @(negedge clk);
        check({tag, "_pulse_len"}, 32'(cur_valid), 32'd0);
        check({tag, "_rdata_hold"}, 32'(cur_rdata), 32'(exp_rdata));
        check({tag, "_err_hold"}, 32'(cur_err), 32'(exp_err));
    endtask

    // Write to addr 2 on the WAIT_CYC=3 instance, then reset d falling edges later.
    task automatic reset_mid(input int d);
        int seen;
        sel_d = 1'b1; we_d = 1'b1; addr_d = 16'd2; wdata_d = 16'h5555; be_d = 2'b11;
        valid_d = 1'b1;
        #1;
        check($sformatf("rstmid%0d_ready", d), 32'(cur_ready), 32'd1);
        @(negedge clk);
        valid_d = 1'b0;
        repeat (d - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check($sformatf("rstmid%0d_ready_in_rst", d), 32'(cur_ready), 32'd0);
        check($sformatf("rstmid%0d_valid_in_rst", d), 32'(cur_valid), 32'd0);
        rst = 1'b0;
        #1;
        check($sformatf("rstmid%0d_rdata_after", d), 32'(cur_rdata), 32'd0);
        check($sformatf("rstmid%0d_err_after", d), 32'(cur_err), 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (cur_valid) seen++;
        end
        check($sformatf("rstmid%0d_no_rsp", d), 32'(seen), 32'd0);
        txn($sformatf("rstmid%0d_readback", d), 1'b1, 1'b0, 16'd2, 16'h0, 2'b00,
            16'h1001, 1'b0);
    endtask

    typedef struct {
        logic        sel;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [21];
        logic [15:0] er;
        logic        ee;
        logic        rs, rw;
        logic [15:0] ra, rd;
        logic [1:0]  rb;

        vecs[0]  = '{1'b0, 1'b1, 16'h0005, 16'h1DFE, 2'b11, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0005, 16'h0000, 2'b00, 16'h1DFE, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 16'h0007, 16'hA001, 2'b11, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 16'h0007, 16'hFFFF, 2'b01, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 16'h0007, 16'h0000, 2'b00, 16'hA0FF, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 16'h0007, 16'h1234, 2'b00, 16'h0000, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 16'h0007, 16'h0000, 2'b00, 16'hA0FF, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 16'h0400, 16'h1234, 2'b11, 16'h0000, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 16'h1000, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 16'h03FF, 16'hBEEF, 2'b11, 16'h0000, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 16'h03FF, 16'h0000, 2'b00, 16'hBEEF, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 16'h0400, 16'h0000, 2'b00, 16'h0000, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 2'b00, 16'h0000, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 16'hFFFF, 16'h1111, 2'b11, 16'h0000, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 16'h03FF, 16'h0000, 2'b00, 16'hBEEF, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 16'h0002, 16'h1001, 2'b11, 16'h0000, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, 16'h1001, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 16'h0009, 16'hABCD, 2'b10, 16'h0000, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 16'h0009, 16'h0000, 2'b00, 16'hAB09, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 16'h0400, 16'h1234, 2'b11, 16'h0000, 1'b1};
        vecs[20] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, 16'h1000, 1'b0};

        rst = 1'b1; valid_d = 1'b0; sel_d = 1'b0; we_d = 1'b0;
        addr_d = '0; wdata_d = '0; be_d = '0;
        repeat (3) @(negedge clk);
        check("rst_ready0", 32'(bus0.req_ready), 32'd0);
        check("rst_ready3", 32'(bus3.req_ready), 32'd0);
        check("rst_valid0", 32'(bus0.rsp_valid), 32'd0);
        check("rst_rdata0", 32'(bus0.rsp_rdata), 32'd0);
        check("rst_err3", 32'(bus3.rsp_err), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_valid0", 32'(bus0.rsp_valid), 32'd0);
        check("post_rst_rdata3", 32'(bus3.rsp_rdata), 32'd0);
        check("post_rst_ready0", 32'(bus0.req_ready), 32'd1);
        @(negedge clk);

        // Known contents for the low 64 words of both instances.
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 64; a++) begin
                model_apply(s[0], 1'b1, 16'(a), 16'h1000 + 16'(a), 2'b11, er, ee);
                txn($sformatf("init%0d_%0d", s, a), s[0], 1'b1, 16'(a), 16'h1000 + 16'(a),
                    2'b11, er, ee);
            end
        end

        for (int i = 0; i < 21; i++) begin
            model_apply(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                        er, ee);
            txn($sformatf("vec%0d", i), vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].be, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // WAIT_CYC=3: ready stays low for four cycles, response only in the fourth.
        sel_d = 1'b1; we_d = 1'b0; addr_d = 16'd2; valid_d = 1'b1;
        #1;
        check("wait3_hs_ready", 32'(cur_ready), 32'd1);
        @(negedge clk);
        valid_d = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("wait3_ready_c%0d", k), 32'(cur_ready), 32'd0);
            check($sformatf("wait3_valid_c%0d", k), 32'(cur_valid), 32'(k == 4));
            if (k == 4) check("wait3_rdata", 32'(cur_rdata), 32'h1001);
            @(negedge clk);
        end
        check("wait3_ready_after", 32'(cur_ready), 32'd1);
        check("wait3_valid_after", 32'(cur_valid), 32'd0);

        reset_mid(2);
        reset_mid(3);

        for (int i = 0; i < 300; i++) begin
            rs = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1024, 65535))
                                             : 16'($urandom_range(0, 63));
            rd = 16'($urandom);
            rb = 2'($urandom);
            model_apply(rs, rw, ra, rd, rb, er, ee);
            txn($sformatf("rnd%0d", i), rs, rw, ra, rd, rb, er, ee);
        end

`ifdef DM_STATS_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            model_apply(1'b0, 1'b0, 16'(i + 1), 16'h0, 2'b00, er, ee);
            txn($sformatf("stat_rd%0d", i), 1'b0, 1'b0, 16'(i + 1), 16'h0, 2'b00, er, ee);
        end
        for (int i = 0; i < 2; i++) begin
            model_apply(1'b0, 1'b1, 16'(i + 10), 16'h7777, 2'b11, er, ee);
            txn($sformatf("stat_wr%0d", i), 1'b0, 1'b1, 16'(i + 10), 16'h7777, 2'b11, er, ee);
        end
        txn("stat_oor", 1'b0, 1'b0, 16'h0500, 16'h0, 2'b00, 16'h0, 1'b1);
        check("stat_rd", 32'(stat_rd0), 32'd3);
        check("stat_wr", 32'(stat_wr0), 32'd2);
        check("stat_err", 32'(stat_err0), 32'd1);
        check("stat_rd3_idle", 32'(stat_rd3), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("stat_rd_clr", 32'(stat_rd0), 32'd0);
        check("stat_wr_clr", 32'(stat_wr0), 32'd0);
        check("stat_err_clr", 32'(stat_err0), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
